// File: rtl/branchwb_arbiter.sv
// Branch writeback arbiter: squash filter, per-FTQ-entry dedup, oldest-to-ROB select, held redirect.
// Latency: FTQ/ROB outputs 1 cycle; redirect valid from the cycle after capture.
// Backpressure: FTQ/ROB paths never stall; redirect is held until i_redirect_rdy or squash-drop.
module branchwb_arbiter #(
    parameter int BRU_NUM   = 2,
    parameter int ROB_IDX_W = 6,
    parameter int FTQ_IDX_W = 4,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 32
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic [BRU_NUM-1:0]                                        i_bwb_vld,
    input  logic [BRU_NUM*(ROB_IDX_W+1)-1:0]                          i_bwb_robIdx,
    input  logic [BRU_NUM*FTQ_IDX_W-1:0]                              i_bwb_ftqIdx,
    input  logic [BRU_NUM-1:0]                                        i_bwb_mispred,
    input  logic [BRU_NUM*PAYLOAD_W-1:0]                              i_bwb_payload,
    input  logic                                                      i_squash_vld,
    input  logic [ROB_IDX_W:0]                                        i_squash_robIdx,
    output logic [BRU_NUM-1:0]                                        o_ftq_vld,
    output logic [BRU_NUM*(ROB_IDX_W+1+FTQ_IDX_W+1+PAYLOAD_W)-1:0]    o_ftq_info,
    output logic                                                      o_rob_vld,
    output logic [ROB_IDX_W+1+FTQ_IDX_W+1+PAYLOAD_W-1:0]              o_rob_info,
    output logic                                                      o_redirect_vld,
    input  logic                                                      i_redirect_rdy,
    output logic [ROB_IDX_W+1+FTQ_IDX_W+1+PAYLOAD_W-1:0]              o_redirect_info,
    output logic [CNT_W-1:0]                                          o_mispred_cnt
);

    localparam int RW     = ROB_IDX_W + 1;
    localparam int INFO_W = RW + FTQ_IDX_W + 1 + PAYLOAD_W;

    typedef struct packed {
        logic [RW-1:0]        rob;
        logic [FTQ_IDX_W-1:0] ftq;
        logic                 mispred;
        logic [PAYLOAD_W-1:0] payload;
    } info_t;

    typedef enum logic {IDLE, PEND} state_t;

    // Wrap-aware age: the MSB flag toggles each time the ROB index wraps.
    function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
        if (a[RW-1] == b[RW-1]) return a[RW-2:0] < b[RW-2:0];
        else                    return a[RW-2:0] > b[RW-2:0];
    endfunction

    // Dedup priority: mispredict first, then age, then lowest channel index.
    function automatic logic beats(input info_t a, input int ia, input info_t b, input int ib);
        if (a.mispred != b.mispred) return a.mispred;
        if (older(a.rob, b.rob))    return 1'b1;
        if (older(b.rob, a.rob))    return 1'b0;
        return ia < ib;
    endfunction

    info_t                       ch [BRU_NUM];
    logic [BRU_NUM-1:0]          surv;
    logic [BRU_NUM-1:0]          ftq_pass;
    logic [BRU_NUM*INFO_W-1:0]   ftq_info_d;
    logic                        rob_found;
    info_t                       rob_best;
    logic                        mis_found;
    info_t                       mis_best;

    state_t                      state_q, state_d;
    info_t                       held_q, held_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    for (genvar g = 0; g < BRU_NUM; g++) begin : g_ch
        assign ch[g] = {i_bwb_robIdx[g*RW +: RW], i_bwb_ftqIdx[g*FTQ_IDX_W +: FTQ_IDX_W],
                        i_bwb_mispred[g], i_bwb_payload[g*PAYLOAD_W +: PAYLOAD_W]};
        assign surv[g] = i_bwb_vld[g] && !(i_squash_vld && older(i_squash_robIdx, ch[g].rob));
        assign ftq_info_d[g*INFO_W +: INFO_W] = ch[g];
    end

    always_comb begin
        ftq_pass = surv;
        for (int i = 0; i < BRU_NUM; i++) begin
            for (int j = 0; j < BRU_NUM; j++) begin
                if (j != i && surv[j] && ch[j].ftq == ch[i].ftq && beats(ch[j], j, ch[i], i))
                    ftq_pass[i] = 1'b0;
            end
        end
    end

    // Strict-older compare keeps the lowest index on exact ties.
    always_comb begin
        rob_found = 1'b0;
        rob_best  = '0;
        mis_found = 1'b0;
        mis_best  = '0;
        for (int j = 0; j < BRU_NUM; j++) begin
            if (surv[j] && (!rob_found || older(ch[j].rob, rob_best.rob))) begin
                rob_found = 1'b1;
                rob_best  = ch[j];
            end
            if (surv[j] && ch[j].mispred && (!mis_found || older(ch[j].rob, mis_best.rob))) begin
                mis_found = 1'b1;
                mis_best  = ch[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mis_found) begin
                    held_d  = mis_best;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (i_squash_vld && older(i_squash_robIdx, held_q.rob)) begin
                    if (mis_found) held_d  = mis_best;
                    else           state_d = IDLE;
                end else if (i_redirect_rdy) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if (mis_found && older(mis_best.rob, held_q.rob)) held_d  = mis_best;
                    else                                              state_d = IDLE;
                end else if (mis_found && older(mis_best.rob, held_q.rob)) begin
                    held_d = mis_best;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ftq_vld  <= '0;
            o_ftq_info <= '0;
            o_rob_vld  <= 1'b0;
            o_rob_info <= '0;
            state_q    <= IDLE;
            held_q     <= '0;
            cnt_q      <= '0;
        end else begin
            o_ftq_vld  <= ftq_pass;
            o_ftq_info <= ftq_info_d;
            o_rob_vld  <= rob_found;
            o_rob_info <= rob_best;
            state_q    <= state_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_redirect_vld  = (state_q == PEND);
    assign o_redirect_info = held_q;
    assign o_mispred_cnt   = cnt_q;

endmodule
